// File: rtl/imem_responder_if.sv
// Fetch request/response bundle between the fetch stage (master) and the
// instruction memory responder (slave).
interface imem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  resp_error;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_error
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr, resp_error
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency word fetch with an in-order
// response queue, credit backpressure, flush on redirect and a preload port.
module imem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int LATENCY        = 2,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    imem_responder_if.slave           bus,
    input  logic                      load_enable,
    input  logic [MEM_WORDS_LOG2-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]     load_data
);
    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
    localparam int STAGES    = LATENCY - 1;
    localparam int SDEPTH    = (STAGES > 0) ? STAGES : 1;
    localparam int CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [DATA_WIDTH-1:0]     mem_q [MEM_WORDS];
    logic [CNT_W-1:0]          outstanding_q;
    logic [CNT_W-1:0]          outstanding_d;
    logic                      reqFire;
    logic                      respFire;
    logic [MEM_WORDS_LOG2-1:0] capIdx;
    logic                      capErr;
    logic [DATA_WIDTH-1:0]     capData;
    logic                      wrValid;
    logic [DATA_WIDTH-1:0]     wrData;
    logic [ADDR_WIDTH-1:0]     wrAddr;
    logic                      wrErr;
    logic [DATA_WIDTH-1:0]     fifoData_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]     fifoAddr_q [QUEUE_DEPTH];
    logic                      fifoErr_q  [QUEUE_DEPTH];
    logic [PTR_W-1:0]          wrPtr_q;
    logic [PTR_W-1:0]          rdPtr_q;
    logic [CNT_W-1:0]          fifoCount_q;
    logic                      headValid;

    // Ready is held low while reset is asserted so it drops without a clock edge.
    assign bus.req_ready = reset && !flush && (outstanding_q < CNT_W'(QUEUE_DEPTH));
    assign reqFire       = bus.req_valid && bus.req_ready;
    assign headValid     = (fifoCount_q != '0);
    assign respFire      = headValid && bus.resp_ready;

    assign capIdx  = bus.req_addr[MEM_WORDS_LOG2+1:2];
    assign capErr  = (bus.req_addr[1:0] != 2'b00) ||
                     ((bus.req_addr >> (MEM_WORDS_LOG2 + 2)) != '0);
    assign capData = capErr ? '0 : mem_q[capIdx];

    // Read-before-write: a same-cycle fetch sees the word as it was before the load.
    always_ff @(posedge clock) begin
        if (load_enable) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({reqFire, respFire})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
        end else if (flush) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    generate
        if (STAGES == 0) begin : gNoStage
            assign wrValid = reqFire;
            assign wrData  = capData;
            assign wrAddr  = bus.req_addr;
            assign wrErr   = capErr;
        end else begin : gStage
            logic [SDEPTH-1:0]     stgValid_q;
            logic [DATA_WIDTH-1:0] stgData_q [SDEPTH];
            logic [ADDR_WIDTH-1:0] stgAddr_q [SDEPTH];
            logic                  stgErr_q  [SDEPTH];

            // Only the valid bits need reset/flush; payload is qualified by them.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    stgValid_q <= '0;
                end else if (flush) begin
                    stgValid_q <= '0;
                end else begin
                    stgValid_q[0] <= reqFire;
                    for (int i = 1; i < SDEPTH; i++) begin
                        stgValid_q[i] <= stgValid_q[i-1];
                    end
                end
            end

            always_ff @(posedge clock) begin
                stgData_q[0] <= capData;
                stgAddr_q[0] <= bus.req_addr;
                stgErr_q[0]  <= capErr;
                for (int i = 1; i < SDEPTH; i++) begin
                    stgData_q[i] <= stgData_q[i-1];
                    stgAddr_q[i] <= stgAddr_q[i-1];
                    stgErr_q[i]  <= stgErr_q[i-1];
                end
            end

            assign wrValid = stgValid_q[STAGES-1];
            assign wrData  = stgData_q[STAGES-1];
            assign wrAddr  = stgAddr_q[STAGES-1];
            assign wrErr   = stgErr_q[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (wrValid) begin
            fifoData_q[wrPtr_q] <= wrData;
            fifoAddr_q[wrPtr_q] <= wrAddr;
            fifoErr_q[wrPtr_q]  <= wrErr;
        end
    end

    // Credit gating bounds delay-line plus FIFO occupancy, so no full check is needed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else if (flush) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (wrValid) begin
                wrPtr_q <= (wrPtr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (respFire) begin
                rdPtr_q <= (rdPtr_q == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
            end
            case ({wrValid, respFire})
                2'b10:   fifoCount_q <= fifoCount_q + CNT_W'(1);
                2'b01:   fifoCount_q <= fifoCount_q - CNT_W'(1);
                default: fifoCount_q <= fifoCount_q;
            endcase
        end
    end

    assign bus.resp_valid = headValid;
    assign bus.resp_data  = headValid ? fifoData_q[rdPtr_q] : '0;
    assign bus.resp_addr  = headValid ? fifoAddr_q[rdPtr_q] : '0;
    assign bus.resp_error = headValid ? fifoErr_q[rdPtr_q]  : 1'b0;
endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder: a shadow memory and an
// expected-response queue predict every output cycle by cycle.
module tb_imem_responder;
    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int MWL         = 10;
    localparam int LATENCY     = 2;
    localparam int QUEUE_DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          err;
        int            acc;
    } exp_t;

    logic           clock;
    logic           reset;
    logic           flush;
    logic           load_enable;
    logic [MWL-1:0] load_addr;
    logic [DW-1:0]  load_data;

    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      acceptCnt = 0;
    exp_t    sbQ[$];
    exp_t    newExp;
    logic [DW-1:0] shadow [1 << MWL];
    logic    expValid;
    logic    expReady;

    imem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS_LOG2(MWL),
        .LATENCY(LATENCY), .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus),
        .load_enable(load_enable), .load_addr(load_addr), .load_data(load_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [AW-1:0] addr, input logic rr,
                                 input logic fl, input logic le, input logic [MWL-1:0] la,
                                 input logic [DW-1:0] ld);
        @(posedge clock);
        #1;
        bus.req_valid  = rv;
        bus.req_addr   = addr;
        bus.resp_ready = rr;
        flush          = fl;
        load_enable    = le;
        load_addr      = la;
        load_data      = ld;
    endtask

    // Monitor: predicts ready/valid from the model queue, checks the head, then
    // applies pop, flush, new request and load in that order.
    always begin
        @(negedge clock);
        if (!reset) begin
            sbQ.delete();
        end else begin
            expValid = (sbQ.size() > 0) && (cyc >= sbQ[0].acc + LATENCY);
            expReady = !flush && (sbQ.size() < QUEUE_DEPTH);
            checkOutput("resp_valid", bus.resp_valid, expValid);
            checkOutput("req_ready", bus.req_ready, expReady);
            if (bus.resp_valid && sbQ.size() > 0) begin
                checkOutput("resp_data", bus.resp_data, sbQ[0].data);
                checkOutput("resp_addr", bus.resp_addr, sbQ[0].addr);
                checkOutput("resp_error", bus.resp_error, sbQ[0].err);
                if (bus.resp_ready) void'(sbQ.pop_front());
            end
            if (flush) begin
                sbQ.delete();
            end else if (bus.req_valid && bus.req_ready) begin
                newExp.addr = bus.req_addr;
                newExp.err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= AW'(1 << (MWL + 2)));
                newExp.data = newExp.err ? '0 : shadow[bus.req_addr[MWL+1:2]];
                newExp.acc  = cyc;
                sbQ.push_back(newExp);
                acceptCnt++;
            end
            if (load_enable) shadow[load_addr] = load_data;
        end
    end

    function automatic logic [AW-1:0] randAddr();
        int sel;
        logic [AW-1:0] a;
        sel = $urandom_range(0, 9);
        a = AW'($urandom_range(0, (1 << MWL) - 1)) << 2;
        if (sel == 7) a = a | AW'($urandom_range(1, 3));
        else if (sel >= 8) a = $urandom | 32'h0000_1000;
        return a;
    endfunction

    initial begin
        int a0;
        reset = 1'b0;
        flush = 1'b0;
        load_enable = 1'b0;
        load_addr = '0;
        load_data = '0;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("reset_req_ready", bus.req_ready, 1'b0);
        checkOutput("reset_resp_data", bus.resp_data, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < (1 << MWL); i++) applyStimulus(0, 0, 1, 0, 1, MWL'(i), $urandom);

        // Basic fetch
        applyStimulus(0, 0, 1, 0, 1, MWL'(16), 32'hDEADBEEF);
        applyStimulus(1, 32'h40, 1, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Credit stall
        a0 = acceptCnt;
        for (int i = 0; i < 6; i++) applyStimulus(1, AW'(i * 4), 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("credit_accepts", acceptCnt - a0, 4);
        repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Errors
        applyStimulus(1, 32'h42, 1, 0, 0, 0, 0);
        applyStimulus(1, 32'h1000, 1, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Flush mid-flight
        for (int i = 0; i < 3; i++) applyStimulus(1, AW'(32'h100 + i * 4), 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h80, 0, 1, 0, 0, 0);
        applyStimulus(1, 32'h84, 1, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Load/read collision
        applyStimulus(0, 0, 1, 0, 1, MWL'(5), 32'h1111);
        applyStimulus(1, 32'h14, 1, 0, 1, MWL'(5), 32'h2222);
        applyStimulus(1, 32'h14, 1, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Async reset with responses queued
        applyStimulus(1, 32'h20, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h24, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("async_req_ready", bus.req_ready, 1'b0);
        checkOutput("async_resp_data", bus.resp_data, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (5) applyStimulus(0, 0, 1, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), randAddr(), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) == 0),
                          MWL'($urandom_range(0, (1 << MWL) - 1)), $urandom);
        end
        repeat (10) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
